axi4_user_yanker: RTL and testbench
===================================

// Module: axi4_user_yanker
// PURPOSE
// - Sits directly downstream of the AXI4 ID indexer. Consumes its echo sideband
//   (tl_state_size, tl_state_source, extra_id) on AW/AR and stores it in per-ID FIFOs.
// - Drives the slave port with echo-free AXI4.
// - Re-attaches the stored echo to the matching B/R responses, so slaves need not carry user bits.
// PARAMETERS
// - ID_W      4   AXI ID width on both sides
// - CAPACITY  4   outstanding transactions per ID per direction (power of 2, >=1)
// - SIZE_W    4   echo tl_state_size width
// - SRC_W     6   echo tl_state_source width
// - XID_W     2   echo extra_id width
// PORTS
// - clock                             in   1      sole clock
// - reset                             in   1      asynchronous, active-low
// - in_aw_{valid,ready,bits_*}        in/out  AXI4 AW plus echo_{tl_state_size,tl_state_source,extra_id}
// - in_w_*, out_w_*                   pass    64b data, 8b strb, last: wired straight through
// - in_b_{valid,ready,bits_id,resp}   out/in  B plus the re-attached echo fields
// - in_ar_*, in_r_*                   as AW/B; R also carries data[63:0] and last
// - out_aw_*, out_ar_*                out     AXI4 AW/AR without echo (id ID_W, addr 32)
// - out_b_*, out_r_*                  in      AXI4 B/R without echo
// - err_unexpected                    out  1  sticky; present only with AXI4_YANKER_ERR_EN
// BEHAVIOUR
// - Two queue banks (write, read), each 2^ID_W FIFOs of CAPACITY x (SIZE_W+SRC_W+XID_W) bits.
// - AW path:
//   - out_aw_valid = in_aw_valid & !wfull[in_aw_id]
//   - in_aw_ready  = out_aw_ready & !wfull[in_aw_id]
//   - Push echo into wq[id] on in_aw fire. All non-echo fields pass combinationally, 0 latency.
// - AR path: identical, using rq.
// - B path:
//   - valid/ready/id/resp pass through.
//   - Echo = head of wq[out_b_id], combinational.
//   - Pop wq[out_b_id] on B fire.
// - R path:
//   - Echo = head of rq[out_r_id] on every beat.
//   - Pop only on R fire with last=1.
// - Full queue: no bypass. Ready stays low while full even if the same queue pops this cycle.
//   It re-opens the next cycle.
// - Push and pop of the same queue in one cycle both take effect; count is unchanged.
// - Response to an empty queue (protocol violation):
//   - No pop.
//   - Echo outputs are 0.
//   - Counts and pointers are not disturbed.
// - Pointers wrap modulo CAPACITY. Count width is clog2(CAPACITY)+1.
// - Reset (async assert, sync deassert handled upstream):
//   - All counts and pointers go to 0; err_unexpected goes to 0.
//   - Ready outputs then follow out_*_ready, since all queues are empty.
//   - Reset mid-burst drops all stored echo; in-flight responses then hit the empty-queue case.
// - No valid depends on its own ready. No combinational path exists from in_*_ready to out_*_valid.
// CONFIGURATION
// - AXI4_YANKER_ERR_EN defined:
//   - err_unexpected sets on a B or R fire whose queue is empty.
//   - It stays set until reset.
// - AXI4_YANKER_ERR_EN undefined:
//   - The err_unexpected port and its logic are absent.
//   - Empty-queue behaviour is otherwise identical.
// STRUCTURE
// - Shared package axi4_yanker_pkg:
//   - echo_t packed struct {size, source, extra_id}
//   - ID_W / echo width localparams
// - One sub-module axi4_yanker_id_queue: a single FIFO (push, pop, full, empty, head).
//   - Instantiated 2 x 2^ID_W times via generate.
// - Full/empty flags and heads are one-hot muxed by ID in the top level.
// TESTING
// - AR id=3, echo{size=6,src=0x2A,xid=1} fire; 4-beat R id=3 -> all 4 beats carry that echo;
//   rq[3] empty after last.
// - 4 AW on id=5, out_aw_ready=1 -> 5th AW: in_aw_ready=0, out_aw_valid=0.
//   - One B id=5 -> ready returns the following cycle.
// - Interleaved R id=1/id=2 with different echos, no last until the end
//   -> each beat's echo matches its own ID; FIFO order holds per ID.
// - Same-cycle AW push and B pop on id=0 holding count=2 -> count stays 2;
//   the next B returns the second echo.
// - B id=7 with wq[7] empty -> echo=0, no state change.
//   - With AXI4_YANKER_ERR_EN, err_unexpected=1 next cycle and stays set.
// - Assert reset low with 3 queued AR -> queues empty; in_ar_ready==out_ar_ready after release.

Source files
------------

// File: rtl/axi4_yanker_pkg.sv
// Shared types and sizes for the AXI4 user yanker.
// echo_t packs the echo sideband carried by AW/AR and re-attached to B/R.
package axi4_yanker_pkg;

  localparam int unsigned ID_W    = 4;
  localparam int unsigned SIZE_W  = 4;
  localparam int unsigned SRC_W   = 6;
  localparam int unsigned XID_W   = 2;
  localparam int unsigned ECHO_W  = SIZE_W + SRC_W + XID_W;
  localparam int unsigned NUM_IDS = 1 << ID_W;

  typedef struct packed {
    logic [SIZE_W-1:0] size;
    logic [SRC_W-1:0]  source;
    logic [XID_W-1:0]  extra_id;
  } echo_t;

  // Pointer width that stays legal for a single-entry queue.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/axi4_yanker_id_queue.sv
// Single echo FIFO for one ID in one direction.
// Ports: clock, reset (async active-low), push/push_data, pop,
//        full, empty, head (zero while empty).
// A push while full or a pop while empty is ignored.
module axi4_yanker_id_queue
  import axi4_yanker_pkg::*;
#(
  parameter int unsigned CAPACITY = 4
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  push,
  input  echo_t push_data,
  input  logic  pop,
  output logic  full,
  output logic  empty,
  output echo_t head
);

  localparam int unsigned PTR_W = ptr_width(CAPACITY);
  localparam int unsigned CNT_W = $clog2(CAPACITY) + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(CAPACITY - 1);
  localparam logic [CNT_W-1:0] CAP_CNT  = CNT_W'(CAPACITY);

  echo_t            mem_q [CAPACITY];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CAP_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/axi4_user_yanker.sv
// AXI4 user yanker: strips the echo sideband from AW/AR, stores it per ID,
// and re-attaches it to the matching B/R responses.
// Ports: clock, reset (async active-low);
//   in_aw/in_ar  : AXI4 request + echo from upstream; out_aw/out_ar: echo-free
//   in_w/out_w   : W channel passed straight through
//   in_b/in_r    : responses upstream with echo;      out_b/out_r  : echo-free
//   err_unexpected (only with AXI4_YANKER_ERR_EN): sticky, set on a B or R
//   fire whose queue is empty.
module axi4_user_yanker
  import axi4_yanker_pkg::*;
#(
  parameter int unsigned CAPACITY = 4
) (
  input  logic              clock,
  input  logic              reset,
  // AW
  input  logic              in_aw_valid,
  output logic              in_aw_ready,
  input  logic [ID_W-1:0]   in_aw_bits_id,
  input  logic [31:0]       in_aw_bits_addr,
  input  logic [7:0]        in_aw_bits_len,
  input  logic [2:0]        in_aw_bits_size,
  input  logic [1:0]        in_aw_bits_burst,
  input  logic [SIZE_W-1:0] in_aw_bits_echo_tl_state_size,
  input  logic [SRC_W-1:0]  in_aw_bits_echo_tl_state_source,
  input  logic [XID_W-1:0]  in_aw_bits_echo_extra_id,
  output logic              out_aw_valid,
  input  logic              out_aw_ready,
  output logic [ID_W-1:0]   out_aw_bits_id,
  output logic [31:0]       out_aw_bits_addr,
  output logic [7:0]        out_aw_bits_len,
  output logic [2:0]        out_aw_bits_size,
  output logic [1:0]        out_aw_bits_burst,
  // W
  input  logic              in_w_valid,
  output logic              in_w_ready,
  input  logic [63:0]       in_w_bits_data,
  input  logic [7:0]        in_w_bits_strb,
  input  logic              in_w_bits_last,
  output logic              out_w_valid,
  input  logic              out_w_ready,
  output logic [63:0]       out_w_bits_data,
  output logic [7:0]        out_w_bits_strb,
  output logic              out_w_bits_last,
  // B
  output logic              in_b_valid,
  input  logic              in_b_ready,
  output logic [ID_W-1:0]   in_b_bits_id,
  output logic [1:0]        in_b_bits_resp,
  output logic [SIZE_W-1:0] in_b_bits_echo_tl_state_size,
  output logic [SRC_W-1:0]  in_b_bits_echo_tl_state_source,
  output logic [XID_W-1:0]  in_b_bits_echo_extra_id,
  input  logic              out_b_valid,
  output logic              out_b_ready,
  input  logic [ID_W-1:0]   out_b_bits_id,
  input  logic [1:0]        out_b_bits_resp,
  // AR
  input  logic              in_ar_valid,
  output logic              in_ar_ready,
  input  logic [ID_W-1:0]   in_ar_bits_id,
  input  logic [31:0]       in_ar_bits_addr,
  input  logic [7:0]        in_ar_bits_len,
  input  logic [2:0]        in_ar_bits_size,
  input  logic [1:0]        in_ar_bits_burst,
  input  logic [SIZE_W-1:0] in_ar_bits_echo_tl_state_size,
  input  logic [SRC_W-1:0]  in_ar_bits_echo_tl_state_source,
  input  logic [XID_W-1:0]  in_ar_bits_echo_extra_id,
  output logic              out_ar_valid,
  input  logic              out_ar_ready,
  output logic [ID_W-1:0]   out_ar_bits_id,
  output logic [31:0]       out_ar_bits_addr,
  output logic [7:0]        out_ar_bits_len,
  output logic [2:0]        out_ar_bits_size,
  output logic [1:0]        out_ar_bits_burst,
  // R
  output logic              in_r_valid,
  input  logic              in_r_ready,
  output logic [ID_W-1:0]   in_r_bits_id,
  output logic [63:0]       in_r_bits_data,
  output logic [1:0]        in_r_bits_resp,
  output logic              in_r_bits_last,
  output logic [SIZE_W-1:0] in_r_bits_echo_tl_state_size,
  output logic [SRC_W-1:0]  in_r_bits_echo_tl_state_source,
  output logic [XID_W-1:0]  in_r_bits_echo_extra_id,
  input  logic              out_r_valid,
  output logic              out_r_ready,
  input  logic [ID_W-1:0]   out_r_bits_id,
  input  logic [63:0]       out_r_bits_data,
  input  logic [1:0]        out_r_bits_resp,
  input  logic              out_r_bits_last
`ifdef AXI4_YANKER_ERR_EN
  ,
  output logic              err_unexpected
`endif
);

  logic [NUM_IDS-1:0] w_full, w_empty, w_push, w_pop;
  logic [NUM_IDS-1:0] r_full, r_empty, r_push, r_pop;
  echo_t              w_head [NUM_IDS];
  echo_t              r_head [NUM_IDS];
  echo_t              aw_echo, ar_echo, b_echo, r_echo;
  logic               aw_fire, ar_fire, b_fire, r_fire;

  assign aw_echo = {in_aw_bits_echo_tl_state_size, in_aw_bits_echo_tl_state_source,
                    in_aw_bits_echo_extra_id};
  assign ar_echo = {in_ar_bits_echo_tl_state_size, in_ar_bits_echo_tl_state_source,
                    in_ar_bits_echo_extra_id};

  // Requests: a full queue blocks both sides; no bypass from a same-cycle pop.
  assign out_aw_valid     = in_aw_valid & ~w_full[in_aw_bits_id];
  assign in_aw_ready      = out_aw_ready & ~w_full[in_aw_bits_id];
  assign aw_fire          = in_aw_valid & in_aw_ready;
  assign out_aw_bits_id   = in_aw_bits_id;
  assign out_aw_bits_addr = in_aw_bits_addr;
  assign out_aw_bits_len  = in_aw_bits_len;
  assign out_aw_bits_size = in_aw_bits_size;
  assign out_aw_bits_burst = in_aw_bits_burst;

  assign out_ar_valid     = in_ar_valid & ~r_full[in_ar_bits_id];
  assign in_ar_ready      = out_ar_ready & ~r_full[in_ar_bits_id];
  assign ar_fire          = in_ar_valid & in_ar_ready;
  assign out_ar_bits_id   = in_ar_bits_id;
  assign out_ar_bits_addr = in_ar_bits_addr;
  assign out_ar_bits_len  = in_ar_bits_len;
  assign out_ar_bits_size = in_ar_bits_size;
  assign out_ar_bits_burst = in_ar_bits_burst;

  assign out_w_valid     = in_w_valid;
  assign in_w_ready      = out_w_ready;
  assign out_w_bits_data = in_w_bits_data;
  assign out_w_bits_strb = in_w_bits_strb;
  assign out_w_bits_last = in_w_bits_last;

  // Responses: handshake passes through, echo comes from the head of the ID's queue.
  assign in_b_valid     = out_b_valid;
  assign out_b_ready    = in_b_ready;
  assign in_b_bits_id   = out_b_bits_id;
  assign in_b_bits_resp = out_b_bits_resp;
  assign b_fire         = out_b_valid & in_b_ready;
  assign b_echo         = w_head[out_b_bits_id];
  assign in_b_bits_echo_tl_state_size   = b_echo.size;
  assign in_b_bits_echo_tl_state_source = b_echo.source;
  assign in_b_bits_echo_extra_id        = b_echo.extra_id;

  assign in_r_valid     = out_r_valid;
  assign out_r_ready    = in_r_ready;
  assign in_r_bits_id   = out_r_bits_id;
  assign in_r_bits_data = out_r_bits_data;
  assign in_r_bits_resp = out_r_bits_resp;
  assign in_r_bits_last = out_r_bits_last;
  assign r_fire         = out_r_valid & in_r_ready;
  assign r_echo         = r_head[out_r_bits_id];
  assign in_r_bits_echo_tl_state_size   = r_echo.size;
  assign in_r_bits_echo_tl_state_source = r_echo.source;
  assign in_r_bits_echo_extra_id        = r_echo.extra_id;

  // One-hot push/pop selects; a response to an empty queue pops nothing.
  assign w_push = aw_fire ? (NUM_IDS'(1) << in_aw_bits_id) : '0;
  assign r_push = ar_fire ? (NUM_IDS'(1) << in_ar_bits_id) : '0;
  assign w_pop  = (b_fire & ~w_empty[out_b_bits_id]) ? (NUM_IDS'(1) << out_b_bits_id) : '0;
  assign r_pop  = (r_fire & out_r_bits_last & ~r_empty[out_r_bits_id]) ?
                  (NUM_IDS'(1) << out_r_bits_id) : '0;

  for (genvar g = 0; g < NUM_IDS; g++) begin : g_queue
    axi4_yanker_id_queue #(.CAPACITY(CAPACITY)) u_wq (
      .clock    (clock),
      .reset    (reset),
      .push     (w_push[g]),
      .push_data(aw_echo),
      .pop      (w_pop[g]),
      .full     (w_full[g]),
      .empty    (w_empty[g]),
      .head     (w_head[g])
    );
    axi4_yanker_id_queue #(.CAPACITY(CAPACITY)) u_rq (
      .clock    (clock),
      .reset    (reset),
      .push     (r_push[g]),
      .push_data(ar_echo),
      .pop      (r_pop[g]),
      .full     (r_full[g]),
      .empty    (r_empty[g]),
      .head     (r_head[g])
    );
  end

`ifdef AXI4_YANKER_ERR_EN
  logic err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if ((b_fire & w_empty[out_b_bits_id]) | (r_fire & r_empty[out_r_bits_id])) begin
      err_q <= 1'b1;
    end
  end

  assign err_unexpected = err_q;
`endif

endmodule

// File: tb/tb_axi4_user_yanker.sv
module tb_axi4_user_yanker;
  import axi4_yanker_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic              in_aw_valid, in_aw_ready, out_aw_valid, out_aw_ready;
  logic [ID_W-1:0]   in_aw_bits_id, out_aw_bits_id;
  logic [31:0]       in_aw_bits_addr, out_aw_bits_addr;
  logic [7:0]        in_aw_bits_len, out_aw_bits_len;
  logic [2:0]        in_aw_bits_size, out_aw_bits_size;
  logic [1:0]        in_aw_bits_burst, out_aw_bits_burst;
  logic [SIZE_W-1:0] in_aw_bits_echo_tl_state_size;
  logic [SRC_W-1:0]  in_aw_bits_echo_tl_state_source;
  logic [XID_W-1:0]  in_aw_bits_echo_extra_id;
  logic              in_w_valid, in_w_ready, out_w_valid, out_w_ready;
  logic [63:0]       in_w_bits_data, out_w_bits_data;
  logic [7:0]        in_w_bits_strb, out_w_bits_strb;
  logic              in_w_bits_last, out_w_bits_last;
  logic              in_b_valid, in_b_ready, out_b_valid, out_b_ready;
  logic [ID_W-1:0]   in_b_bits_id, out_b_bits_id;
  logic [1:0]        in_b_bits_resp, out_b_bits_resp;
  logic [SIZE_W-1:0] in_b_bits_echo_tl_state_size;
  logic [SRC_W-1:0]  in_b_bits_echo_tl_state_source;
  logic [XID_W-1:0]  in_b_bits_echo_extra_id;
  logic              in_ar_valid, in_ar_ready, out_ar_valid, out_ar_ready;
  logic [ID_W-1:0]   in_ar_bits_id, out_ar_bits_id;
  logic [31:0]       in_ar_bits_addr, out_ar_bits_addr;
  logic [7:0]        in_ar_bits_len, out_ar_bits_len;
  logic [2:0]        in_ar_bits_size, out_ar_bits_size;
  logic [1:0]        in_ar_bits_burst, out_ar_bits_burst;
  logic [SIZE_W-1:0] in_ar_bits_echo_tl_state_size;
  logic [SRC_W-1:0]  in_ar_bits_echo_tl_state_source;
  logic [XID_W-1:0]  in_ar_bits_echo_extra_id;
  logic              in_r_valid, in_r_ready, out_r_valid, out_r_ready;
  logic [ID_W-1:0]   in_r_bits_id, out_r_bits_id;
  logic [63:0]       in_r_bits_data, out_r_bits_data;
  logic [1:0]        in_r_bits_resp, out_r_bits_resp;
  logic              in_r_bits_last, out_r_bits_last;
  logic [SIZE_W-1:0] in_r_bits_echo_tl_state_size;
  logic [SRC_W-1:0]  in_r_bits_echo_tl_state_source;
  logic [XID_W-1:0]  in_r_bits_echo_extra_id;
`ifdef AXI4_YANKER_ERR_EN
  logic              err_unexpected;
`endif

  axi4_user_yanker #(.CAPACITY(4)) dut (
    .clock(clock), .reset(reset),
    .in_aw_valid(in_aw_valid), .in_aw_ready(in_aw_ready), .in_aw_bits_id(in_aw_bits_id),
    .in_aw_bits_addr(in_aw_bits_addr), .in_aw_bits_len(in_aw_bits_len),
    .in_aw_bits_size(in_aw_bits_size), .in_aw_bits_burst(in_aw_bits_burst),
    .in_aw_bits_echo_tl_state_size(in_aw_bits_echo_tl_state_size),
    .in_aw_bits_echo_tl_state_source(in_aw_bits_echo_tl_state_source),
    .in_aw_bits_echo_extra_id(in_aw_bits_echo_extra_id),
    .out_aw_valid(out_aw_valid), .out_aw_ready(out_aw_ready), .out_aw_bits_id(out_aw_bits_id),
    .out_aw_bits_addr(out_aw_bits_addr), .out_aw_bits_len(out_aw_bits_len),
    .out_aw_bits_size(out_aw_bits_size), .out_aw_bits_burst(out_aw_bits_burst),
    .in_w_valid(in_w_valid), .in_w_ready(in_w_ready), .in_w_bits_data(in_w_bits_data),
    .in_w_bits_strb(in_w_bits_strb), .in_w_bits_last(in_w_bits_last),
    .out_w_valid(out_w_valid), .out_w_ready(out_w_ready), .out_w_bits_data(out_w_bits_data),
    .out_w_bits_strb(out_w_bits_strb), .out_w_bits_last(out_w_bits_last),
    .in_b_valid(in_b_valid), .in_b_ready(in_b_ready), .in_b_bits_id(in_b_bits_id),
    .in_b_bits_resp(in_b_bits_resp),
    .in_b_bits_echo_tl_state_size(in_b_bits_echo_tl_state_size),
    .in_b_bits_echo_tl_state_source(in_b_bits_echo_tl_state_source),
    .in_b_bits_echo_extra_id(in_b_bits_echo_extra_id),
    .out_b_valid(out_b_valid), .out_b_ready(out_b_ready), .out_b_bits_id(out_b_bits_id),
    .out_b_bits_resp(out_b_bits_resp),
    .in_ar_valid(in_ar_valid), .in_ar_ready(in_ar_ready), .in_ar_bits_id(in_ar_bits_id),
    .in_ar_bits_addr(in_ar_bits_addr), .in_ar_bits_len(in_ar_bits_len),
    .in_ar_bits_size(in_ar_bits_size), .in_ar_bits_burst(in_ar_bits_burst),
    .in_ar_bits_echo_tl_state_size(in_ar_bits_echo_tl_state_size),
    .in_ar_bits_echo_tl_state_source(in_ar_bits_echo_tl_state_source),
    .in_ar_bits_echo_extra_id(in_ar_bits_echo_extra_id),
    .out_ar_valid(out_ar_valid), .out_ar_ready(out_ar_ready), .out_ar_bits_id(out_ar_bits_id),
    .out_ar_bits_addr(out_ar_bits_addr), .out_ar_bits_len(out_ar_bits_len),
    .out_ar_bits_size(out_ar_bits_size), .out_ar_bits_burst(out_ar_bits_burst),
    .in_r_valid(in_r_valid), .in_r_ready(in_r_ready), .in_r_bits_id(in_r_bits_id),
    .in_r_bits_data(in_r_bits_data), .in_r_bits_resp(in_r_bits_resp),
    .in_r_bits_last(in_r_bits_last),
    .in_r_bits_echo_tl_state_size(in_r_bits_echo_tl_state_size),
    .in_r_bits_echo_tl_state_source(in_r_bits_echo_tl_state_source),
    .in_r_bits_echo_extra_id(in_r_bits_echo_extra_id),
    .out_r_valid(out_r_valid), .out_r_ready(out_r_ready), .out_r_bits_id(out_r_bits_id),
    .out_r_bits_data(out_r_bits_data), .out_r_bits_resp(out_r_bits_resp),
    .out_r_bits_last(out_r_bits_last)
`ifdef AXI4_YANKER_ERR_EN
    , .err_unexpected(err_unexpected)
`endif
  );

  echo_t b_echo_o, r_echo_o;
  assign b_echo_o = {in_b_bits_echo_tl_state_size, in_b_bits_echo_tl_state_source,
                     in_b_bits_echo_extra_id};
  assign r_echo_o = {in_r_bits_echo_tl_state_size, in_r_bits_echo_tl_state_source,
                     in_r_bits_echo_extra_id};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic echo_t mk(input int unsigned s, input int unsigned src, input int unsigned x);
    echo_t e;
    e.size     = SIZE_W'(s);
    e.source   = SRC_W'(src);
    e.extra_id = XID_W'(x);
    return e;
  endfunction

  task automatic idle();
    in_aw_valid = 0; in_aw_bits_id = '0; in_aw_bits_addr = '0; in_aw_bits_len = '0;
    in_aw_bits_size = '0; in_aw_bits_burst = '0; in_aw_bits_echo_tl_state_size = '0;
    in_aw_bits_echo_tl_state_source = '0; in_aw_bits_echo_extra_id = '0; out_aw_ready = 0;
    in_w_valid = 0; in_w_bits_data = '0; in_w_bits_strb = '0; in_w_bits_last = 0;
    out_w_ready = 0; in_b_ready = 0; out_b_valid = 0; out_b_bits_id = '0; out_b_bits_resp = '0;
    in_ar_valid = 0; in_ar_bits_id = '0; in_ar_bits_addr = '0; in_ar_bits_len = '0;
    in_ar_bits_size = '0; in_ar_bits_burst = '0; in_ar_bits_echo_tl_state_size = '0;
    in_ar_bits_echo_tl_state_source = '0; in_ar_bits_echo_extra_id = '0; out_ar_ready = 0;
    in_r_ready = 0; out_r_valid = 0; out_r_bits_id = '0; out_r_bits_data = '0;
    out_r_bits_resp = '0; out_r_bits_last = 0;
  endtask

  task automatic set_aw(input int unsigned id, input echo_t e);
    in_aw_valid = 1; in_aw_bits_id = ID_W'(id); out_aw_ready = 1;
    in_aw_bits_echo_tl_state_size = e.size; in_aw_bits_echo_tl_state_source = e.source;
    in_aw_bits_echo_extra_id = e.extra_id;
  endtask

  task automatic set_ar(input int unsigned id, input echo_t e);
    in_ar_valid = 1; in_ar_bits_id = ID_W'(id); out_ar_ready = 1;
    in_ar_bits_echo_tl_state_size = e.size; in_ar_bits_echo_tl_state_source = e.source;
    in_ar_bits_echo_extra_id = e.extra_id;
  endtask

  // Pass-through vectors applied with all queues empty; valids drop before the edge.
  typedef struct {
    logic        aw_valid;
    logic [3:0]  aw_id;
    logic [31:0] aw_addr;
    logic        aw_ready;
    logic        b_valid;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        b_ready;
    logic [63:0] w_data;
    logic        exp_out_aw_valid;
    logic        exp_in_aw_ready;
  } vec_t;
  vec_t vecs [5];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    echo_t       e_r1 [4];
    int unsigned ids [6];
    logic        lasts [6];
    echo_t       ex [6];

    vecs[0] = '{1'b1, 4'd2,  32'h1000_0040, 1'b1, 1'b0, 4'd0,  2'b00, 1'b0,
                64'h0123_4567_89AB_CDEF, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 4'd9,  32'hDEAD_BEEC, 1'b0, 1'b1, 4'd9,  2'b10, 1'b1,
                64'hFFFF_0000_FFFF_0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 4'd15, 32'h0000_0000, 1'b1, 1'b1, 4'd15, 2'b11, 1'b0,
                64'h0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 4'd0,  32'hFFFF_FFFC, 1'b0, 1'b0, 4'd0,  2'b00, 1'b1,
                64'h8000_0000_0000_0001, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 4'd7,  32'h0000_0008, 1'b1, 1'b1, 4'd7,  2'b01, 1'b1,
                64'h5A5A_5A5A_A5A5_A5A5, 1'b1, 1'b1};

    idle();
    reset = 1'b0;
    out_aw_ready = 1; out_ar_ready = 1;
    repeat (2) @(negedge clock);
    #1;
    chk("reset_aw_ready", 64'(in_aw_ready), 64'd1);
    chk("reset_ar_ready", 64'(in_ar_ready), 64'd1);
    chk("reset_b_valid", 64'(in_b_valid), 64'd0);
`ifdef AXI4_YANKER_ERR_EN
    chk("reset_err", 64'(err_unexpected), 64'd0);
`endif
    @(negedge clock);
    reset = 1'b1;
    idle();

    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      in_aw_valid = vecs[i].aw_valid; in_aw_bits_id = vecs[i].aw_id;
      in_aw_bits_addr = vecs[i].aw_addr; out_aw_ready = vecs[i].aw_ready;
      out_b_valid = vecs[i].b_valid; out_b_bits_id = vecs[i].b_id;
      out_b_bits_resp = vecs[i].b_resp; in_b_ready = vecs[i].b_ready;
      in_w_bits_data = vecs[i].w_data;
      #1;
      chk("vec_out_aw_valid", 64'(out_aw_valid), 64'(vecs[i].exp_out_aw_valid));
      chk("vec_in_aw_ready", 64'(in_aw_ready), 64'(vecs[i].exp_in_aw_ready));
      chk("vec_aw_addr", 64'(out_aw_bits_addr), 64'(vecs[i].aw_addr));
      chk("vec_aw_id", 64'(out_aw_bits_id), 64'(vecs[i].aw_id));
      chk("vec_b_valid", 64'(in_b_valid), 64'(vecs[i].b_valid));
      chk("vec_b_ready", 64'(out_b_ready), 64'(vecs[i].b_ready));
      chk("vec_b_resp", 64'(in_b_bits_resp), 64'(vecs[i].b_resp));
      chk("vec_b_echo_empty", 64'(b_echo_o), 64'd0);
      chk("vec_w_data", out_w_bits_data, vecs[i].w_data);
      #1 idle();
    end

    // AR id=3 then a 4-beat R burst: every beat carries the echo.
    @(negedge clock);
    set_ar(3, mk(6, 'h2A, 1)); in_ar_bits_addr = 32'h0000_2000;
    #1;
    chk("ar_out_valid", 64'(out_ar_valid), 64'd1);
    chk("ar_in_ready", 64'(in_ar_ready), 64'd1);
    chk("ar_out_addr", 64'(out_ar_bits_addr), 64'h2000);
    for (int b = 0; b < 4; b++) begin
      @(negedge clock);
      idle();
      out_r_valid = 1; out_r_bits_id = 4'd3; in_r_ready = 1; out_r_bits_last = (b == 3);
      out_r_bits_data = 64'hA5A5_0000_0000_0000 + 64'(b);
      #1;
      chk("r_burst_echo", 64'(r_echo_o), 64'(mk(6, 'h2A, 1)));
      chk("r_burst_data", in_r_bits_data, 64'hA5A5_0000_0000_0000 + 64'(b));
    end
    @(negedge clock);
    idle(); out_r_valid = 1; out_r_bits_id = 4'd3;
    #1;
    chk("r_burst_empty_after", 64'(r_echo_o), 64'd0);

    // Fill wq[5]; 5th AW blocked; one B reopens it a cycle later.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      idle(); set_aw(5, mk(i, 'h10 + i, i));
      #1 chk("fill_aw_ready", 64'(in_aw_ready), 64'd1);
    end
    @(negedge clock);
    set_aw(5, mk(4, 'h14, 0));
    #1;
    chk("full_aw_ready", 64'(in_aw_ready), 64'd0);
    chk("full_aw_valid", 64'(out_aw_valid), 64'd0);
    @(negedge clock);
    out_b_valid = 1; out_b_bits_id = 4'd5; in_b_ready = 1;
    #1;
    chk("full_pop_no_bypass", 64'(in_aw_ready), 64'd0);
    chk("full_pop_echo", 64'(b_echo_o), 64'(mk(0, 'h10, 0)));
    @(negedge clock);
    out_b_valid = 0;
    #1;
    chk("reopen_aw_ready", 64'(in_aw_ready), 64'd1);
    chk("reopen_aw_valid", 64'(out_aw_valid), 64'd1);
    for (int i = 1; i < 5; i++) begin
      @(negedge clock);
      idle(); out_b_valid = 1; out_b_bits_id = 4'd5; in_b_ready = 1;
      #1 chk("wrap_b_echo", 64'(b_echo_o), 64'(mk(i, 'h10 + i, i)));
    end
    @(negedge clock);
    idle(); out_b_valid = 1; out_b_bits_id = 4'd5;
    #1 chk("wrap_b_empty", 64'(b_echo_o), 64'd0);

    // Interleaved R on id 1 and id 2.
    e_r1[0] = mk(1, 'h01, 1); e_r1[1] = mk(2, 'h02, 2);
    e_r1[2] = mk(9, 'h31, 3); e_r1[3] = mk(10, 'h32, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      idle(); set_ar((i < 2) ? 1 : 2, e_r1[i]);
    end
    ids   = '{1, 2, 1, 2, 1, 2};
    lasts = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    ex    = '{e_r1[0], e_r1[2], e_r1[0], e_r1[2], e_r1[1], e_r1[3]};
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      idle(); out_r_valid = 1; in_r_ready = 1;
      out_r_bits_id = ID_W'(ids[i]); out_r_bits_last = lasts[i];
      #1 chk("interleave_echo", 64'(r_echo_o), 64'(ex[i]));
    end
    @(negedge clock);
    idle(); out_r_valid = 1; out_r_bits_id = 4'd2;
    #1 chk("interleave_empty", 64'(r_echo_o), 64'd0);

    // Same-cycle push and pop on id 0 holding two entries.
    @(negedge clock);
    idle(); set_aw(0, mk(3, 'h05, 1));
    @(negedge clock);
    set_aw(0, mk(7, 'h06, 2));
    @(negedge clock);
    set_aw(0, mk(11, 'h07, 3));
    out_b_valid = 1; out_b_bits_id = 4'd0; in_b_ready = 1;
    #1;
    chk("pushpop_aw_ready", 64'(in_aw_ready), 64'd1);
    chk("pushpop_echo", 64'(b_echo_o), 64'(mk(3, 'h05, 1)));
    @(negedge clock);
    in_aw_valid = 0;
    #1 chk("pushpop_second", 64'(b_echo_o), 64'(mk(7, 'h06, 2)));
    @(negedge clock);
    #1 chk("pushpop_third", 64'(b_echo_o), 64'(mk(11, 'h07, 3)));
    @(negedge clock);
    in_b_ready = 0;
    #1 chk("pushpop_empty", 64'(b_echo_o), 64'd0);

    // B to empty wq[7].
    @(negedge clock);
    idle(); out_b_valid = 1; out_b_bits_id = 4'd7; out_b_bits_resp = 2'b10; in_b_ready = 1;
    #1;
    chk("empty_b_echo", 64'(b_echo_o), 64'd0);
    chk("empty_b_valid", 64'(in_b_valid), 64'd1);
    chk("empty_b_resp", 64'(in_b_bits_resp), 64'd2);
    @(negedge clock);
    idle(); set_aw(7, mk(5, 'h15, 2));
`ifdef AXI4_YANKER_ERR_EN
    #1 chk("err_set", 64'(err_unexpected), 64'd1);
`endif
    @(negedge clock);
    idle(); out_b_valid = 1; out_b_bits_id = 4'd7; in_b_ready = 1;
    #1 chk("empty_b_no_disturb", 64'(b_echo_o), 64'(mk(5, 'h15, 2)));
    @(negedge clock);
    idle(); out_b_valid = 1; out_b_bits_id = 4'd7;
    #1 chk("empty_b_after", 64'(b_echo_o), 64'd0);
`ifdef AXI4_YANKER_ERR_EN
    chk("err_sticky", 64'(err_unexpected), 64'd1);
`endif

    // Reset with queued AR entries drops them.
    @(negedge clock);
    idle(); set_ar(4, mk(1, 'h21, 1));
    @(negedge clock);
    set_ar(4, mk(2, 'h22, 2));
    @(negedge clock);
    set_ar(6, mk(3, 'h23, 3));
    @(negedge clock);
    idle(); reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1 chk("post_reset_ar_ready0", 64'(in_ar_ready), 64'd0);
    out_ar_ready = 1; in_ar_bits_id = 4'd4;
    #1 chk("post_reset_ar_ready1", 64'(in_ar_ready), 64'd1);
    out_r_valid = 1; out_r_bits_id = 4'd4;
    #1 chk("post_reset_r4_empty", 64'(r_echo_o), 64'd0);
    out_r_bits_id = 4'd6;
    #1 chk("post_reset_r6_empty", 64'(r_echo_o), 64'd0);
`ifdef AXI4_YANKER_ERR_EN
    chk("post_reset_err", 64'(err_unexpected), 64'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      idle(); set_ar(4, mk(8 + i, 'h30 + i, i));
      #1 chk("post_reset_fill", 64'(in_ar_ready), 64'd1);
    end
    @(negedge clock);
    set_ar(4, mk(12, 'h34, 0));
    #1 chk("post_reset_full", 64'(in_ar_ready), 64'd0);
    @(negedge clock);
    idle(); out_r_valid = 1; out_r_bits_id = 4'd4; out_r_bits_last = 1; in_r_ready = 1;
    #1 chk("post_reset_new_echo", 64'(r_echo_o), 64'(mk(8, 'h30, 0)));

    @(negedge clock);
    idle();
    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
